// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared constants and types for the LED / seven-segment display blocks.
//
//   BCD_DIGITS     : number of decimal digits shown on the display (4).
//   BCD_MAX        : largest value the display can show exactly (9999).
//   state_t        : converter FSM state (IDLE, SHIFT, DONE).
//   bcd_digits_for : number of BCD digits needed to hold any unsigned value
//                    of a given bit width, never fewer than BCD_DIGITS.
// -----------------------------------------------------------------------------
package led_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_MAX    = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ceil(width * log10(2)) in integer arithmetic; log10(2) ~= 0.30103.
  function automatic int bcd_digits_for(input int width);
    int n;
    n = (width * 30103 + 99999) / 100000;
    return (n < BCD_DIGITS) ? BCD_DIGITS : n;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
//   Double-dabble correction for one BCD digit: a digit of 5 or more gets 3
//   added so that the following left shift carries correctly into the next
//   decimal digit. Purely combinational.
//
//   digit_in  [3:0] : BCD digit before correction
//   digit_out [3:0] : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_converter.sv
// -----------------------------------------------------------------------------
// bin2bcd_converter
//   Sequential double-dabble converter from an unsigned binary value to four
//   BCD digits for the seven-segment display. One iteration per clock.
//
//   Ports
//     clk        : system clock, rising edge
//     rst_n      : synchronous active-low reset
//     start      : conversion request, accepted in IDLE or DONE
//     bin_in     : value to convert, captured on the accepting edge only
//     busy       : high while the shift iterations run
//     valid      : high while bcd_data_* hold a completed result
//     overflow   : with valid, the captured value was larger than 9999
//     bcd_data_0 : thousands digit
//     bcd_data_1 : hundreds digit
//     bcd_data_2 : tens digit
//     bcd_data_3 : ones digit
//     state_dbg  : current FSM state (state_t encoding), for observation
//
//   Handshake: start is a level request sampled on each rising edge. It is
//   accepted only in IDLE/DONE when no load is pending; requests during a
//   conversion are dropped, not queued. valid stays high until the next
//   accepted start or a reset, so holding start high gives one conversion
//   per completion.
//
//   Timing (edge 0 = accepting edge): edge 0 captures bin_in and clears
//   valid/overflow; edge 1 enters SHIFT and raises busy; edges 2..DATA_WIDTH+1
//   perform the DATA_WIDTH iterations, the last one writing the result
//   straight to the outputs and entering DONE. busy is therefore high for
//   exactly DATA_WIDTH cycles and valid rises DATA_WIDTH+1 cycles after
//   acceptance. All outputs are registered.
// -----------------------------------------------------------------------------
module bin2bcd_converter
  import led_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bin_in,
  output logic                  busy,
  output logic                  valid,
  output logic                  overflow,
  output logic [3:0]            bcd_data_0,
  output logic [3:0]            bcd_data_1,
  output logic [3:0]            bcd_data_2,
  output logic [3:0]            bcd_data_3,
  output logic [1:0]            state_dbg
);

  // Internal digit count is wide enough for any DATA_WIDTH-bit value, so
  // intermediate values never lose a carry even when the result overflows.
  localparam int NDIG  = bcd_digits_for(DATA_WIDTH);
  localparam int BCD_W = NDIG * 4;
  localparam int SR_W  = BCD_W + DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int CMP_W = (DATA_WIDTH > 14) ? DATA_WIDTH : 14;

  state_t            state;
  logic              load_pending;
  logic              ovf_latched;
  logic [CNT_W-1:0]  iter_cnt;
  logic [SR_W-1:0]   shift_q;
  logic [SR_W-1:0]   shift_adj;
  logic [SR_W-1:0]   shift_nxt;
  logic [CMP_W-1:0]  bin_cmp;
  logic              last_iter;

  assign state_dbg = state;

  // Shift register layout: {bcd digit NDIG-1 .. digit 0, binary}.
  for (genvar d = 0; d < NDIG; d++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (shift_q  [DATA_WIDTH + 4*d +: 4]),
      .digit_out (shift_adj[DATA_WIDTH + 4*d +: 4])
    );
  end

  assign shift_adj[DATA_WIDTH-1:0] = shift_q[DATA_WIDTH-1:0];
  assign shift_nxt                 = shift_adj << 1;

  assign bin_cmp   = CMP_W'(bin_in);
  assign last_iter = (iter_cnt == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      load_pending <= 1'b0;
      ovf_latched  <= 1'b0;
      iter_cnt     <= '0;
      shift_q      <= '0;
      busy         <= 1'b0;
      valid        <= 1'b0;
      overflow     <= 1'b0;
      bcd_data_0   <= 4'd0;
      bcd_data_1   <= 4'd0;
      bcd_data_2   <= 4'd0;
      bcd_data_3   <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load_pending) begin
            // Value was captured on the previous edge; start iterating.
            load_pending <= 1'b0;
            iter_cnt     <= '0;
            busy         <= 1'b1;
            state        <= SHIFT;
          end else if (start) begin
            shift_q      <= {{BCD_W{1'b0}}, bin_in};
            ovf_latched  <= (bin_cmp > CMP_W'(BCD_MAX));
            valid        <= 1'b0;
            overflow     <= 1'b0;
            load_pending <= 1'b1;
          end
        end

        SHIFT: begin
          shift_q <= shift_nxt;
          if (last_iter) begin
            state    <= DONE;
            busy     <= 1'b0;
            valid    <= 1'b1;
            overflow <= ovf_latched;
            // Outputs take the final iteration directly, so they never
            // show an intermediate value.
            if (ovf_latched) begin
              bcd_data_0 <= 4'd9;
              bcd_data_1 <= 4'd9;
              bcd_data_2 <= 4'd9;
              bcd_data_3 <= 4'd9;
            end else begin
              bcd_data_0 <= shift_nxt[DATA_WIDTH + 12 +: 4];
              bcd_data_1 <= shift_nxt[DATA_WIDTH + 8  +: 4];
              bcd_data_2 <= shift_nxt[DATA_WIDTH + 4  +: 4];
              bcd_data_3 <= shift_nxt[DATA_WIDTH      +: 4];
            end
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          load_pending <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_converter
//   Directed and random stimulus for bin2bcd_converter (DATA_WIDTH = 16).
//   Expected digits come from decimal arithmetic on the applied value.
// -----------------------------------------------------------------------------
module tb_bin2bcd_converter;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] bin_in;
  logic         busy;
  logic         valid;
  logic         overflow;
  logic [3:0]   bcd_data_0;
  logic [3:0]   bcd_data_1;
  logic [3:0]   bcd_data_2;
  logic [3:0]   bcd_data_3;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  bin2bcd_converter #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .valid      (valid),
    .overflow   (overflow),
    .bcd_data_0 (bcd_data_0),
    .bcd_data_1 (bcd_data_1),
    .bcd_data_2 (bcd_data_2),
    .bcd_data_3 (bcd_data_3),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] prev_d   = 16'h0000;

  function automatic logic [15:0] digits();
    return {bcd_data_0, bcd_data_1, bcd_data_2, bcd_data_3};
  endfunction

  // Reference: four decimal digits, or all nines above the display range.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    if (v > 9999) return 16'h9999;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion from IDLE/DONE. With disturb set, a second request with a
  // different value is raised while busy and must be ignored.
  task automatic run_conv(input int value, input bit disturb);
    logic [15:0] exp_d;
    logic        exp_o;
    int          n;
    int          busy_n;
    bit          held;
    exp_o = (value > 9999);
    exp_d = ref_bcd(value);
    exp_q.push_back(exp_d);
    start  = 1'b1;
    bin_in = W'(value);
    tick();
    start  = 1'b0;
    bin_in = W'($urandom);
    check("valid_clear_on_accept", 32'(valid), 32'd0);
    n = 0; busy_n = 0; held = 1'b1;
    while (n < 40) begin
      tick();
      n++;
      if (disturb && n == 5) begin
        start  = 1'b1;
        bin_in = W'(7777);
      end
      if (disturb && n == 10) start = 1'b0;
      if (busy) busy_n++;
      if (valid) break;
      if (digits() !== prev_d || overflow !== 1'b0) held = 1'b0;
    end
    check($sformatf("latency_%0d", value), 32'(n), 32'd17);
    check($sformatf("busy_cycles_%0d", value), 32'(busy_n), 32'd16);
    check($sformatf("digits_hold_%0d", value), 32'(held), 32'd1);
    check($sformatf("digits_%0d", value), 32'(digits()), 32'(exp_q.pop_front()));
    check($sformatf("overflow_%0d", value), 32'(overflow), 32'(exp_o));
    check($sformatf("busy_done_%0d", value), 32'(busy), 32'd0);
    prev_d = exp_d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v;
    int rise1;
    int rise2;
    int valid_n;
    logic prev_valid;

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_digits", 32'(digits()), 32'h0000);
    rst_n = 1'b1;
    tick();

    // Directed values, including both sides of the display range.
    run_conv(1234, 1'b0);
    run_conv(0, 1'b0);
    run_conv(9999, 1'b0);
    run_conv(10000, 1'b0);
    run_conv(65535, 1'b0);

    // Request while busy with a different value: result must stay 0042.
    run_conv(42, 1'b1);
    repeat (3) tick();
    check("no_spurious_restart_valid", 32'(valid), 32'd1);
    check("no_spurious_restart_digits", 32'(digits()), 32'h0042);

    // New request from DONE.
    run_conv(5678, 1'b0);

    // Random values across the full range and inside the display range.
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 65535));
      run_conv(v, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 9999));
      run_conv(v, 1'b0);
    end

    // start held high: one conversion per completion.
    start  = 1'b1;
    bin_in = W'(321);
    rise1 = -1; rise2 = -1; prev_valid = valid;
    tick();
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (valid && !prev_valid) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      prev_valid = valid;
    end
    start = 1'b0;
    check("b2b_first_valid", 32'(rise1), 32'd17);
    check("b2b_second_valid", 32'(rise2), 32'd35);
    check("b2b_digits", 32'(digits()), 32'h0321);
    prev_d = 16'h0321;
    repeat (3) tick();

    // Reset in the middle of a conversion.
    start  = 1'b1;
    bin_in = W'(4321);
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_digits", 32'(digits()), 32'h0000);
    check("midrst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    valid_n = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (valid) valid_n++;
    end
    check("midrst_no_valid", 32'(valid_n), 32'd0);
    prev_d = 16'h0000;

    // Recovery after reset.
    run_conv(2024, 1'b0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_converter.md
BIN2BCD_CONVERTER -- requirements
Module: bin2bcd_converter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of the unsigned binary input.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  conversion request; sampled on rising edge.
REQ-005 SHALL have port bin_in  input  DATA_WIDTH  unsigned value; sampled only when start is accepted.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port valid  output  1  high while the bcd_data_* outputs hold a completed result.
REQ-008 SHALL have port overflow  output  1  high with valid when the latched value exceeded 9999.
REQ-009 SHALL have ports bcd_data_0, bcd_data_1, bcd_data_2, bcd_data_3  output  4 each  BCD digits: thousands, hundreds, tens, ones respectively. These map directly to the seg7_display inputs of the same names.

Function
REQ-010 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-011 SHALL accept start only in IDLE or DONE, latch bin_in, clear valid and overflow, set busy, and enter SHIFT on the next edge.
REQ-012 SHALL ignore start while busy; bin_in changes during SHIFT SHALL NOT affect the result.
REQ-013 SHALL in SHIFT perform one double-dabble iteration per cycle for exactly DATA_WIDTH cycles:
  - add 3 to every BCD digit >= 5;
  - shift the combined BCD/binary register left by one.
REQ-014 SHALL use ceil(DATA_WIDTH*log10(2)) internal BCD digits, i.e. 5 for DATA_WIDTH=16, so no intermediate value is lost.
REQ-015 SHALL after the final iteration enter DONE, deassert busy, and assert valid and register the bcd_data_* outputs in the same edge.
REQ-016 SHALL produce valid exactly DATA_WIDTH+1 cycles after the edge that accepted start (17 cycles for the default).
REQ-017 SHALL on overflow (latched value > 9999) drive all four digits to 4'd9 and assert overflow; otherwise overflow SHALL be 0 and the digits SHALL be the exact decimal value with leading zeros.
REQ-018 SHALL hold bcd_data_* and overflow stable from valid assertion until the next accepted start.
REQ-019 SHALL keep bcd_data_* at their previous values (not intermediate values) throughout SHIFT.
REQ-020 SHALL treat start asserted in DONE as a new request: valid falls on the next edge and a new conversion begins.
REQ-021 SHALL treat start held continuously high as back-to-back requests, one per completion.

Reset
REQ-022 SHALL on rst_n=0 at a clock edge enter IDLE with busy=0, valid=0, overflow=0 and all bcd_data_*=4'd0.
REQ-023 SHALL abort any conversion in progress on reset, with no valid pulse afterwards until a new start is accepted.

Structure
REQ-024 SHALL take BCD_DIGITS=4, BCD_MAX=9999 and the state enum type from the shared led_pkg package.
REQ-025 SHALL place the per-digit add-3 correction in a combinational sub-module bcd_digit_adjust, instantiated once per internal digit.
REQ-026 SHALL contain no combinational path from any input to any output.

Verification
REQ-027 SHALL cover: start with bin_in=1234 -> 17 cycles later valid=1, digits 1,2,3,4, overflow=0.
REQ-028 SHALL cover:
  - bin_in=0 -> digits 0,0,0,0, overflow=0;
  - bin_in=9999 -> digits 9,9,9,9, overflow=0.
REQ-029 SHALL cover:
  - bin_in=10000 -> digits 9,9,9,9, overflow=1;
  - bin_in=65535 -> digits 9,9,9,9, overflow=1.
REQ-030 SHALL cover: start with 42, then start with 7777 while busy and bin_in changed -> result 0,0,4,2 only, with busy pulsing exactly 16 cycles.
REQ-031 SHALL cover: rst_n=0 at cycle 8 of a conversion -> busy=0, valid=0, digits 0 next edge, and no later valid without a new start.
REQ-032 SHALL cover: start in DONE with bin_in=5678 -> valid low next edge, digits hold the old value during SHIFT, then 5,6,7,8 valid 17 cycles after acceptance.
